c5efa7_fpga_bup_qsys_cpu_mulx_seq: RTL and testbench
====================================================

C5EFA7_FPGA_BUP_QSYS_CPU_MULX_SEQ -- requirements
Module: c5efa7_fpga_bup_qsys_cpu_mulx_seq

Interface
REQ-001 SHALL have parameter: MUL_LAT, 1, partial-product multiplier pipeline depth in cycles (legal 1..3).
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: mul_start  input  1  request; accepted only when mul_busy=0.
REQ-005 SHALL have port: mul_op  input  2  00 low word, 01 mulxuu, 10 mulxsu, 11 mulxss; sampled with mul_start.
REQ-006 SHALL have ports: mul_src1 and mul_src2, each input, 32 bits, operands sampled with mul_start.
REQ-007 SHALL have port: mul_kill  input  1  cancels operation in flight.
REQ-008 SHALL have port: mul_busy  output  1  high from acceptance cycle +1 until done or kill.
REQ-009 SHALL have port: mul_done  output  1  single-cycle pulse with valid mul_result.
REQ-010 SHALL have port: mul_result  output  32  low product word (op 00) or high product word (other ops), held until next done.

Function
REQ-011 SHALL use states IDLE, ISSUE, DRAIN, FIX, DONE; IDLE->ISSUE on accepted start; ISSUE->DRAIN after last partial issued; DRAIN->FIX after MUL_LAT cycles; FIX->DONE; DONE->IDLE.
REQ-012 SHALL, at the accepting edge (cycle N), latch |src1|, |src2| as 32-bit unsigned magnitudes: src1 treated signed for ops 10/11, src2 signed for op 11 only; op 00 always unsigned; latch neg = sign1 XOR sign2.
REQ-013 SHALL issue one 16x16 unsigned partial product per cycle in cycles N+1..N+4 in order lo*lo, hi1*lo2, lo1*hi2, hi*hi, through an internal registered multiplier of depth MUL_LAT.
REQ-014 SHALL accumulate each partial into a 64-bit accumulator at its 16-bit-aligned offset (0, 16, 16, 32) when it emerges; accumulator cleared at acceptance.
REQ-015 SHALL, in FIX, two's-complement negate the 64-bit accumulator when neg=1, else pass it unchanged.
REQ-016 SHALL assert mul_done in cycle N+6+MUL_LAT and update mul_result on that same edge; mul_busy deasserts in the same cycle.
REQ-017 SHALL ignore mul_start while mul_busy=1 or mul_done=1; no queuing.
REQ-018 SHALL, on mul_kill in any non-IDLE state, return to IDLE next edge, suppress mul_done, leave mul_result unchanged; kill concurrent with start in IDLE: start wins.
REQ-019 SHALL produce the exact result for the full operand range, including 0x80000000 magnitudes (no overflow in magnitude or accumulator).

Reset
REQ-020 SHALL, while reset=1, force state IDLE, mul_busy=0, mul_done=0, mul_result=0, accumulator=0, multiplier pipeline cleared, regardless of clk.
REQ-021 SHALL, on reset asserted mid-operation, discard the operation; no mul_done after release.

Configuration
REQ-022 SHALL honour macro MULX_SEQ_LOW_FAST_EN: when defined, op 00 issues only three partials (hi*hi skipped), skips FIX, and asserts mul_done at N+4+MUL_LAT; when undefined, every op issues four partials and completes at N+6+MUL_LAT.

Verification
REQ-023 SHALL cover: MUL_LAT=1, op 01, 0xFFFFFFFF x 0xFFFFFFFF, start at N -> mul_done at N+7, mul_result=0xFFFFFFFE.
REQ-024 SHALL cover: op 00, 0x00010003 x 0x00020005 -> mul_result=0x000B000F; op 01 same operands -> 0x00000002.
REQ-025 SHALL cover: op 11, 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF; op 11, 0x80000000 x 0x80000000 -> 0x40000000; op 10, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-026 SHALL cover: second mul_start at N+2 while busy -> ignored, exactly one done; mul_kill at N+3 -> no done, mul_busy=0 at N+4, mul_result retains prior value.
REQ-027 SHALL cover: reset pulsed at N+3 -> outputs zero immediately, no done; fresh op afterwards completes correctly.
REQ-028 SHALL cover: MULX_SEQ_LOW_FAST_EN defined, MUL_LAT=2, op 00, 0x00010003 x 0x00020005 -> done at N+6, mul_result=0x000B000F.

Source files
------------

// File: rtl/c5efa7_fpga_bup_qsys_cpu_mulx_seq.sv
// Sequential 32x32 multiplier built from four 16x16 partial products through a MUL_LAT-deep pipeline.
// Optional macro MULX_SEQ_LOW_FAST_EN: op 00 skips the hi*hi partial and the FIX step.
module c5efa7_fpga_bup_qsys_cpu_mulx_seq #(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mul_start,
    input  logic [1:0]  mul_op,
    input  logic [31:0] mul_src1,
    input  logic [31:0] mul_src2,
    input  logic        mul_kill,
    output logic        mul_busy,
    output logic        mul_done,
    output logic [31:0] mul_result
);
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] mag1_q, mag2_q;
    logic        neg_q, low_q;
    logic [1:0]  idx_q, drain_cnt_q;
    logic [63:0] acc_q;
    logic        busy_q, done_q;
    logic [31:0] result_q;
    logic [31:0] pp_q  [MUL_LAT];
    logic [1:0]  off_q [MUL_LAT];
    logic        vld_q [MUL_LAT];

    logic        accept_s, issue_s, last_s, drain_last_s, kill_s, sgn1_s, sgn2_s;
    logic [31:0] opa_s, opb_s;
    logic [1:0]  off_s;

    assign accept_s     = (state_q == IDLE) && mul_start && !done_q;
    assign issue_s      = (state_q == ISSUE);
    assign kill_s       = mul_kill && (state_q != IDLE);
    assign drain_last_s = (drain_cnt_q == 2'(MUL_LAT - 1));
    assign sgn1_s       = mul_op[1] && mul_src1[31];
    assign sgn2_s       = (mul_op == 2'b11) && mul_src2[31];
`ifdef MULX_SEQ_LOW_FAST_EN
    assign last_s       = (idx_q == (low_q ? 2'd2 : 2'd3));
`else
    assign last_s       = (idx_q == 2'd3);
`endif

    assign mul_busy   = busy_q;
    assign mul_done   = done_q;
    assign mul_result = result_q;

    // Partial-product operand halves and accumulator offset for the current issue slot
    always_comb begin
        opa_s = {16'd0, mag1_q[15:0]};
        opb_s = {16'd0, mag2_q[15:0]};
        off_s = 2'd0;
        case (idx_q)
            2'd0: begin opa_s = {16'd0, mag1_q[15:0]};  opb_s = {16'd0, mag2_q[15:0]};  off_s = 2'd0; end
            2'd1: begin opa_s = {16'd0, mag1_q[31:16]}; opb_s = {16'd0, mag2_q[15:0]};  off_s = 2'd1; end
            2'd2: begin opa_s = {16'd0, mag1_q[15:0]};  opb_s = {16'd0, mag2_q[31:16]}; off_s = 2'd1; end
            default: begin opa_s = {16'd0, mag1_q[31:16]}; opb_s = {16'd0, mag2_q[31:16]}; off_s = 2'd2; end
        endcase
    end

    // Next-state logic; kill overrides everything except IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = accept_s ? ISSUE : IDLE;
            ISSUE: state_d = last_s ? DRAIN : ISSUE;
            DRAIN: begin
                if (drain_last_s) begin
`ifdef MULX_SEQ_LOW_FAST_EN
                    state_d = low_q ? DONE : FIX;
`else
                    state_d = FIX;
`endif
                end else begin
                    state_d = DRAIN;
                end
            end
            FIX:   state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_s) begin
            state_d = IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Operand magnitudes, sign, issue index and drain counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag1_q      <= 32'd0;
            mag2_q      <= 32'd0;
            neg_q       <= 1'b0;
            low_q       <= 1'b0;
            idx_q       <= 2'd0;
            drain_cnt_q <= 2'd0;
        end else begin
            if (accept_s) begin
                mag1_q <= sgn1_s ? (32'd0 - mul_src1) : mul_src1;
                mag2_q <= sgn2_s ? (32'd0 - mul_src2) : mul_src2;
                neg_q  <= sgn1_s ^ sgn2_s;
                low_q  <= (mul_op == 2'b00);
                idx_q  <= 2'd0;
            end else if (issue_s) begin
                idx_q  <= idx_q + 2'd1;
            end
            drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + 2'd1 : 2'd0;
        end
    end

    // Registered multiplier pipeline; a kill flushes every valid bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                pp_q[i]  <= 32'd0;
                off_q[i] <= 2'd0;
                vld_q[i] <= 1'b0;
            end
        end else begin
            pp_q[0]  <= opa_s * opb_s;
            off_q[0] <= off_s;
            vld_q[0] <= issue_s && !kill_s;
            for (int i = 1; i < MUL_LAT; i++) begin
                pp_q[i]  <= pp_q[i-1];
                off_q[i] <= off_q[i-1];
                vld_q[i] <= vld_q[i-1] && !kill_s;
            end
        end
    end

    // Accumulator: cleared on accept, sums emerging partials, negated in FIX
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= 64'd0;
        end else if (accept_s) begin
            acc_q <= 64'd0;
        end else if ((state_q == FIX) && neg_q) begin
            acc_q <= 64'd0 - acc_q;
        end else if (vld_q[MUL_LAT-1]) begin
            acc_q <= acc_q + ({32'd0, pp_q[MUL_LAT-1]} << {off_q[MUL_LAT-1], 4'b0000});
        end else begin
            acc_q <= acc_q;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            busy_q <= (state_d != IDLE);
            done_q <= (state_q == DONE) && !mul_kill;
            if ((state_q == DONE) && !mul_kill) begin
                result_q <= low_q ? acc_q[31:0] : acc_q[63:32];
            end
        end
    end
endmodule

// File: tb/tb_c5efa7_fpga_bup_qsys_cpu_mulx_seq.sv
// Scoreboard bench: stimulus pushes expected result and completion cycle, monitor checks on mul_done.
module tb_c5efa7_fpga_bup_qsys_cpu_mulx_seq;
`ifdef MULX_SEQ_LOW_FAST_EN
    localparam int LAT  = 2;
    localparam bit FAST = 1'b1;
`else
    localparam int LAT  = 1;
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mul_start = 1'b0;
    logic [1:0]  mul_op = 2'b00;
    logic [31:0] mul_src1 = 32'd0;
    logic [31:0] mul_src2 = 32'd0;
    logic        mul_kill = 1'b0;
    logic        mul_busy, mul_done;
    logic [31:0] mul_result;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          total = 0;
    int          passed = 0;
    int          done_cnt = 0;
    logic [31:0] last_res = 32'd0;

    c5efa7_fpga_bup_qsys_cpu_mulx_seq #(.MUL_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .mul_start(mul_start), .mul_op(mul_op),
        .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_kill(mul_kill),
        .mul_busy(mul_busy), .mul_done(mul_done), .mul_result(mul_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: full 64-bit product of sign/zero-extended operands.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb, p;
        xa = (op[1]) ? {{32{a[31]}}, a} : {32'd0, a};
        xb = (op == 2'b11) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = xa * xb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int op_lat(input logic [1:0] op);
        return (FAST && op == 2'b00) ? 4 + LAT : 6 + LAT;
    endfunction

    // Monitor: pops the scoreboard on every done, flags late or stray completions
    always @(negedge clk) begin
        if (!reset) begin
            if (mul_done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_done: got done required none (cycle %0d)", cyc);
                end else begin
                    chk("result", {32'd0, mul_result}, {32'd0, sb[0].res});
                    chk("done_cycle", 64'(cyc), 64'(sb[0].due));
                    last_res = sb[0].res;
                    void'(sb.pop_front());
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                total++;
                $display("FAIL missing_done: got none required done at cycle %0d", sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] e, output int n);
        int guard = 0;
        while ((mul_busy || mul_done) && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        mul_start = 1'b1; mul_op = op; mul_src1 = a; mul_src2 = b;
        n = cyc + 1;
        sb.push_back('{res: e, due: n + op_lat(op)});
        @(posedge clk); #1;
        mul_start = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 60) begin
            @(posedge clk); #1; guard++;
        end
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1);
    end

    initial begin
        int n, d0;
        logic [1:0]  op;
        logic [31:0] a, b;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {63'd0, mul_busy}, 64'd0);
        chk("reset_done", {63'd0, mul_done}, 64'd0);
        chk("reset_result", {32'd0, mul_result}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, n);
        @(posedge clk); #1;
        chk("busy_after_accept", {63'd0, mul_busy}, 64'd1);
        wait_drain();
        start_op(2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, n); wait_drain();
        start_op(2'b01, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002, n); wait_drain();
        start_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, n); wait_drain();
        start_op(2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, n); wait_drain();
        start_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n); wait_drain();

        // Second start while busy must be dropped
        d0 = done_cnt;
        start_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, ref_mul(2'b01, 32'h1234_5678, 32'h9ABC_DEF0), n);
        mul_start = 1'b1; mul_op = 2'b00; mul_src1 = 32'h7; mul_src2 = 32'h9;
        @(posedge clk); #1;
        mul_start = 1'b0;
        wait_drain();
        repeat (12) @(posedge clk);
        #1;
        chk("single_done_on_ignored_start", 64'(done_cnt - d0), 64'd1);

        // Kill mid-operation
        d0 = done_cnt;
        start_op(2'b11, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'd0, n);
        @(posedge clk); #1;
        mul_kill = 1'b1;
        void'(sb.pop_back());
        @(posedge clk); #1;
        mul_kill = 1'b0;
        @(posedge clk); #1;
        chk("kill_busy", {63'd0, mul_busy}, 64'd0);
        chk("kill_result_kept", {32'd0, mul_result}, {32'd0, last_res});
        repeat (15) @(posedge clk);
        #1;
        chk("kill_no_done", 64'(done_cnt - d0), 64'd0);

        // Reset mid-operation
        d0 = done_cnt;
        start_op(2'b01, 32'hCAFE_0001, 32'h0000_1234, 32'd0, n);
        @(posedge clk); #3;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("midreset_busy", {63'd0, mul_busy}, 64'd0);
        chk("midreset_done", {63'd0, mul_done}, 64'd0);
        chk("midreset_result", {32'd0, mul_result}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("midreset_no_done", 64'(done_cnt - d0), 64'd0);
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, ref_mul(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), n);
        wait_drain();

        // Randomized traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = rnd_operand();
            b  = rnd_operand();
            start_op(op, a, b, ref_mul(op, a, b), n);
            if ($urandom_range(0, 1) == 1) wait_drain();
        end
        wait_drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
